// File: rtl/mazesolver_oci_dct_pkg.sv
// Shared definitions for the OCI trace symbol packer and its output slot.
// Holds the frame geometry, the frame record and the flush state encoding.
package mazesolver_oci_dct_pkg;

    localparam int DCT_SYM_W   = 2;
    localparam int DCT_NUM_SYM = 15;
    localparam int DCT_BUF_W   = DCT_SYM_W * DCT_NUM_SYM;
    localparam int DCT_CNT_W   = 4;

    // Symbol counts used by the frame-close decisions, sized to the count field
    localparam logic [DCT_CNT_W-1:0] DCT_FULL_CNT  = DCT_CNT_W'(DCT_NUM_SYM);
    localparam logic [DCT_CNT_W-1:0] DCT_SPLIT_CNT = DCT_CNT_W'(DCT_NUM_SYM - 1);

    typedef struct packed {
        logic [DCT_BUF_W-1:0] buffer;
        logic [DCT_CNT_W-1:0] count;
    } dct_frame_t;

    typedef enum logic [1:0] {
        FL_IDLE,
        FL_ENDING,
        FL_ENDED
    } flush_state_t;

endpackage

// File: rtl/mazesolver_soc_nios2_qsys_0_oci_dct_slot.sv
// One-entry valid/ready output register holding a packed trace frame.
// The frame contents are only rewritten on a load, so they stay stable
// while the slot is empty.
module mazesolver_soc_nios2_qsys_0_oci_dct_slot
    import mazesolver_oci_dct_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  dct_frame_t load_frame,
    input  logic       ready,
    output logic       valid,
    output dct_frame_t frame
);

    // Load wins over a same-cycle drain so back-to-back frames stay valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            frame <= '0;
        end else if (load) begin
            valid <= 1'b1;
            frame <= load_frame;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mazesolver_soc_nios2_qsys_0_oci_dct_packer.sv
// Trace symbol packer: gathers 1-2 two-bit symbols per cycle into 30-bit
// frames of up to 15 symbols and sequences end-of-test flushing.
// Optional build macro OCI_DCT_STALL_CNT_EN adds a saturating stall counter
// output (stall_cnt) counting cycles where input is offered but not taken.
module mazesolver_soc_nios2_qsys_0_oci_dct_packer
    import mazesolver_oci_dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [1:0]           in_nsym,
    input  logic [3:0]           in_data,
    output logic                 in_ready,
    input  logic                 flush,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic [DCT_BUF_W-1:0] dct_buffer,
    output logic [DCT_CNT_W-1:0] dct_count,
    output logic                 test_ending,
    output logic                 test_has_ended
`ifdef OCI_DCT_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    logic [DCT_BUF_W-1:0] acc_q;
    logic [DCT_CNT_W-1:0] acc_cnt_q;
    flush_state_t         fl_state;

    logic                 slot_free;
    logic                 data_ok;
    logic                 sym_pair;
    logic                 flush_close;
    logic [DCT_BUF_W-1:0] merged_acc;
    logic [DCT_CNT_W-1:0] merged_cnt;
    logic                 close;
    dct_frame_t           close_frame;
    logic [DCT_BUF_W-1:0] next_acc;
    logic [DCT_CNT_W-1:0] next_cnt;
    dct_frame_t           slot_frame;

    assign slot_free   = !frame_valid || frame_ready;
    assign in_ready    = !test_has_ended && slot_free;
    assign sym_pair    = (in_nsym == 2'd2);
    assign data_ok     = in_valid && in_ready && ((in_nsym == 2'd1) || sym_pair);
    assign flush_close = test_ending && slot_free && (acc_cnt_q != '0);

    // Merge any accepted symbols into the accumulator and decide whether a frame closes
    always_comb begin
        merged_acc  = acc_q;
        merged_cnt  = acc_cnt_q;
        close       = 1'b0;
        close_frame = '0;
        next_acc    = acc_q;
        next_cnt    = acc_cnt_q;
        if (data_ok) begin
            if (sym_pair) begin
                merged_acc = {acc_q[DCT_BUF_W-5:0], in_data[1:0], in_data[3:2]};
                merged_cnt = acc_cnt_q + 4'd2;
            end else begin
                merged_acc = {acc_q[DCT_BUF_W-3:0], in_data[1:0]};
                merged_cnt = acc_cnt_q + 4'd1;
            end
        end
        if (data_ok && sym_pair && (acc_cnt_q == DCT_SPLIT_CNT)) begin
            close              = 1'b1;
            close_frame.buffer = acc_q;
            close_frame.count  = acc_cnt_q;
            next_acc           = {{(DCT_BUF_W-4){1'b0}}, in_data[1:0], in_data[3:2]};
            next_cnt           = 4'd2;
        end else if ((merged_cnt == DCT_FULL_CNT) || flush_close) begin
            close              = 1'b1;
            close_frame.buffer = merged_acc;
            close_frame.count  = merged_cnt;
            next_acc           = '0;
            next_cnt           = '0;
        end else begin
            next_acc = merged_acc;
            next_cnt = merged_cnt;
        end
    end

    // Accumulator register; a reset throws away any partial frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q     <= '0;
            acc_cnt_q <= '0;
        end else begin
            acc_q     <= next_acc;
            acc_cnt_q <= next_cnt;
        end
    end

    // Flush sequencer: wait for the accumulator and output slot to empty, then end for good
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fl_state       <= FL_IDLE;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            case (fl_state)
                FL_IDLE: begin
                    if (flush) begin
                        fl_state    <= FL_ENDING;
                        test_ending <= 1'b1;
                    end
                end
                FL_ENDING: begin
                    if ((acc_cnt_q == '0) && slot_free && !data_ok) begin
                        fl_state       <= FL_ENDED;
                        test_ending    <= 1'b0;
                        test_has_ended <= 1'b1;
                    end
                end
                FL_ENDED: begin
                    fl_state <= FL_ENDED;
                end
                default: begin
                    fl_state       <= FL_IDLE;
                    test_ending    <= 1'b0;
                    test_has_ended <= 1'b0;
                end
            endcase
        end
    end

    mazesolver_soc_nios2_qsys_0_oci_dct_slot u_slot (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (close),
        .load_frame (close_frame),
        .ready      (frame_ready),
        .valid      (frame_valid),
        .frame      (slot_frame)
    );

    assign dct_buffer = slot_frame.buffer;
    assign dct_count  = slot_frame.count;

`ifdef OCI_DCT_STALL_CNT_EN
    // Count cycles where the source offers a group but is held off, saturating at all-ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mazesolver_soc_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the OCI trace symbol packer with hand-computed frames.
// Covers full frames, the 14+2 split, backpressure, flush and reset.
module tb_mazesolver_soc_nios2_qsys_0_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [1:0]  in_nsym;
    logic [3:0]  in_data;
    logic        in_ready;
    logic        flush;
    logic        frame_valid;
    logic        frame_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
`ifdef OCI_DCT_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mazesolver_soc_nios2_qsys_0_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_nsym        (in_nsym),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .flush          (flush),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
`ifdef OCI_DCT_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    // Advance one clock and sample just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all inputs, then let combinational outputs settle
    task automatic applyStimulus(input logic v, input logic [1:0] n, input logic [3:0] d,
                                 input logic fr, input logic fl);
        in_valid    = v;
        in_nsym     = n;
        in_data     = d;
        frame_ready = fr;
        flush       = fl;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("rst_frame_valid", 32'(frame_valid), 32'h0);
        checkOutput("rst_buffer", 32'(dct_buffer), 32'h0);
        checkOutput("rst_count", 32'(dct_count), 32'h0);
        checkOutput("rst_test_ending", 32'(test_ending), 32'h0);
        checkOutput("rst_has_ended", 32'(test_has_ended), 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
        reset_n = 1'b1;
        tick();

        // 15 singles 01,10,11,00,... -> 0x1B1B1B1B, count 15
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, 2'd1, 4'((i + 1) % 4), 1'b1, 1'b0);
            tick();
        end
        checkOutput("full_not_yet", 32'(frame_valid), 32'h0);
        applyStimulus(1'b1, 2'd1, 4'd3, 1'b1, 1'b0);
        tick();
        checkOutput("full_valid", 32'(frame_valid), 32'h1);
        checkOutput("full_buffer", 32'(dct_buffer), 32'h1B1B1B1B);
        checkOutput("full_count", 32'(dct_count), 32'd15);
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
        tick();
        checkOutput("drain_valid", 32'(frame_valid), 32'h0);
        checkOutput("hold_buffer", 32'(dct_buffer), 32'h1B1B1B1B);

        // Illegal group sizes complete the handshake but carry no data
        applyStimulus(1'b1, 2'd3, 4'hF, 1'b1, 1'b0);
        checkOutput("nsym3_ready", 32'(in_ready), 32'h1);
        tick();
        applyStimulus(1'b1, 2'd0, 4'hF, 1'b1, 1'b0);
        tick();

        // 7 pairs (first=11, second=00) then pair (first=10, second=01): 14-symbol frame
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 2'd2, 4'b0011, 1'b1, 1'b0);
            tick();
        end
        checkOutput("split_not_yet", 32'(frame_valid), 32'h0);
        applyStimulus(1'b1, 2'd2, 4'b0110, 1'b1, 1'b0);
        tick();
        checkOutput("split_valid", 32'(frame_valid), 32'h1);
        checkOutput("split_buffer", 32'(dct_buffer), 32'h0CCCCCCC);
        checkOutput("split_count", 32'(dct_count), 32'd14);

        // Backpressure: frame held, source stalled for three cycles
        applyStimulus(1'b1, 2'd1, 4'd3, 1'b0, 1'b0);
        checkOutput("bp_in_ready", 32'(in_ready), 32'h0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("bp_valid", 32'(frame_valid), 32'h1);
        checkOutput("bp_buffer", 32'(dct_buffer), 32'h0CCCCCCC);
        checkOutput("bp_count", 32'(dct_count), 32'd14);
`ifdef OCI_DCT_STALL_CNT_EN
        checkOutput("stall_cnt3", 32'(stall_cnt), 32'd3);
`endif
        applyStimulus(1'b1, 2'd1, 4'd3, 1'b1, 1'b0);
        checkOutput("bp_release_ready", 32'(in_ready), 32'h1);
        tick();
        checkOutput("bp_drained", 32'(frame_valid), 32'h0);
        // Retained pair 10,01 plus 13 symbols of 11 -> 0x27FFFFFF
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 2'd1, 4'd3, 1'b1, 1'b0);
            tick();
        end
        checkOutput("remainder_valid", 32'(frame_valid), 32'h1);
        checkOutput("remainder_buffer", 32'(dct_buffer), 32'h27FFFFFF);
        checkOutput("remainder_count", 32'(dct_count), 32'd15);
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
        tick();

        // 5 symbols then flush -> partial frame 0x1B1, count 5
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'd1, 4'((i + 1) % 4), 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 1'b1);
        tick();
        checkOutput("flush_ending", 32'(test_ending), 32'h1);
        checkOutput("flush_no_frame_yet", 32'(frame_valid), 32'h0);
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
        tick();
        checkOutput("flush_valid", 32'(frame_valid), 32'h1);
        checkOutput("flush_buffer", 32'(dct_buffer), 32'h1B1);
        checkOutput("flush_count", 32'(dct_count), 32'd5);
        checkOutput("flush_not_ended", 32'(test_has_ended), 32'h0);
        tick();
        checkOutput("ended", 32'(test_has_ended), 32'h1);
        checkOutput("ended_ending_clr", 32'(test_ending), 32'h0);
        checkOutput("ended_drained", 32'(frame_valid), 32'h0);
        applyStimulus(1'b1, 2'd1, 4'd1, 1'b1, 1'b1);
        checkOutput("ended_in_ready", 32'(in_ready), 32'h0);
        tick();
        tick();
        checkOutput("ended_sticky", 32'(test_has_ended), 32'h1);
        checkOutput("ended_no_frame", 32'(frame_valid), 32'h0);

        // Flush from reset-idle ends two cycles later with no frame
        reset_n = 1'b0;
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 1'b1);
        tick();
        checkOutput("idle_flush_ending", 32'(test_ending), 32'h1);
        checkOutput("idle_flush_not_ended", 32'(test_has_ended), 32'h0);
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
        tick();
        checkOutput("idle_flush_ended", 32'(test_has_ended), 32'h1);
        checkOutput("idle_flush_no_frame", 32'(frame_valid), 32'h0);

        // Mid-frame reset with a frame held and a partial remainder
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 2'd2, 4'b0011, 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 2'd1, 4'd1, 1'b0, 1'b0);
        tick();
        checkOutput("pre_reset_valid", 32'(frame_valid), 32'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(frame_valid), 32'h0);
        checkOutput("async_rst_buffer", 32'(dct_buffer), 32'h0);
        checkOutput("async_rst_count", 32'(dct_count), 32'h0);
`ifdef OCI_DCT_STALL_CNT_EN
        checkOutput("async_rst_stall", 32'(stall_cnt), 32'h0);
`endif
        applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 2'd1, 4'((i + 1) % 4), 1'b1, 1'b0);
            tick();
        end
        checkOutput("clean_valid", 32'(frame_valid), 32'h1);
        checkOutput("clean_buffer", 32'(dct_buffer), 32'h1B1B1B1B);
        checkOutput("clean_count", 32'(dct_count), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
